// File: rtl/bf_io_pkg.sv
// rtl/bf_io_pkg.sv - shared constants and types for the brainfuck core character I/O blocks
package bf_io_pkg;

    localparam int CHAR_WIDTH          = 8;
    localparam int FRAME_BITS          = 10;
    localparam int DEFAULT_CLK_PER_BIT = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/bf_char_fifo.sv
// rtl/bf_char_fifo.sv - circular character FIFO with explicit occupancy counter
module bf_char_fifo
    import bf_io_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [CHAR_WIDTH-1:0]      i_data,
    input  logic                       i_pop,
    output logic [CHAR_WIDTH-1:0]      o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [FIFO_ADDR_WIDTH:0]   o_count
);

    localparam int                     DEPTH     = 1 << FIFO_ADDR_WIDTH;
    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

    logic [CHAR_WIDTH-1:0]      r_mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [FIFO_ADDR_WIDTH:0]   r_count;
    logic                       w_pop_ok;
    logic                       w_push_ok;

    // A pop frees the head slot on the same edge, so a push into a full FIFO is still taken then.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array; contents need no reset because the counter gates every read.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the array depth; the count tracks occupancy independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bf_uart_tx_buffer.sv
// rtl/bf_uart_tx_buffer.sv - buffered 8N1 UART transmitter fed by the core's output strobe
module bf_uart_tx_buffer
    import bf_io_pkg::*;
#(
    parameter int CLK_PER_BIT     = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sendingChar,
    input  logic [CHAR_WIDTH-1:0]    sendedChar,
    input  logic                     clear_overflow,
    output logic                     tx,
    output logic                     busy,
    output logic [FIFO_ADDR_WIDTH:0] fifo_count,
    output logic                     overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);

    uart_state_t           r_state;
    uart_state_t           w_next_state;
    logic [15:0]           r_baud;
    logic [15:0]           w_baud_next;
    logic [2:0]            r_bit_idx;
    logic [2:0]            w_bit_idx_next;
    logic [CHAR_WIDTH-1:0] r_shift;
    logic [CHAR_WIDTH-1:0] w_shift_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  r_overflow;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_baud_last;
    logic [CHAR_WIDTH-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [FIFO_ADDR_WIDTH:0] w_count;

    bf_char_fifo #(
        .FIFO_ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (sendingChar),
        .i_data  (sendedChar),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_drop      = sendingChar & w_full & ~w_pop;

    // Frame sequencer: pops the next byte at IDLE or at the end of STOP, so frames run back to back.
    always_comb begin
        w_next_state   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = '0;
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_last) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_next_state   = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            ST_DATA: begin
                if (w_baud_last) begin
                    w_baud_next    = '0;
                    w_shift_next   = {1'b0, r_shift[CHAR_WIDTH-1:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = ST_STOP;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            ST_STOP: begin
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_next_state = ST_START;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 16'd1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_baud_next  = '0;
            end
        endcase

        // The line level is derived from the state being entered so tx comes straight from a flop.
        case (w_next_state)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    // Sequencer registers; reset aborts any frame in flight and returns the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    // Sticky drop flag; a drop on the clearing edge keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE) | (w_count != '0);
    assign fifo_count = w_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_bf_uart_tx_buffer.sv
// tb/tb_bf_uart_tx_buffer.sv - directed self-checking bench for bf_uart_tx_buffer
module tb_bf_uart_tx_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sendingChar = 1'b0;
    logic [7:0] sendedChar = 8'h00;
    logic       clear_overflow = 1'b0;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bf_uart_tx_buffer #(
        .CLK_PER_BIT     (4),
        .FIFO_ADDR_WIDTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sendingChar    (sendingChar),
        .sendedChar     (sendedChar),
        .clear_overflow (clear_overflow),
        .tx             (tx),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples every falling edge, 4 samples per bit, one record per 40-cycle frame.
    typedef struct {
        logic [9:0] bits;
        int         gap;
        int         start;
        bit         clean;
    } frame_t;

    frame_t     rxq[$];
    frame_t     mon_f;
    logic [39:0] mon_samp;
    int         mon_j = 0;
    int         mon_gap = 0;
    int         mon_start = 0;
    bit         mon_active = 0;
    logic       prev_busy = 1'b0;
    int         busy_fall = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 0;
            mon_gap    = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active  = 1;
                mon_samp    = '0;
                mon_samp[0] = tx;
                mon_j       = 1;
                mon_start   = cyc;
            end else begin
                mon_gap++;
            end
        end else begin
            mon_samp[mon_j] = tx;
            mon_j++;
            if (mon_j == 40) begin
                mon_f.clean = 1;
                for (int k = 0; k < 10; k++) begin
                    mon_f.bits[k] = mon_samp[4*k];
                    for (int m = 1; m < 4; m++)
                        if (mon_samp[4*k+m] !== mon_samp[4*k]) mon_f.clean = 0;
                end
                mon_f.gap   = mon_gap;
                mon_f.start = mon_start;
                rxq.push_back(mon_f);
                mon_active = 0;
                mon_gap    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        sendingChar = 1'b1;
        sendedChar  = d;
        tick();
        sendingChar = 1'b0;
    endtask

    task automatic wait_frames(input string name, input int n, input int limit);
        for (int k = 0; k < limit && rxq.size() < n; k++) tick();
        chk({name, "_frames"}, rxq.size() >= n, 1);
    endtask

    task automatic wait_idle(input string name, input int limit);
        for (int k = 0; k < limit && busy !== 1'b0; k++) tick();
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    // Expected line levels: bit i is the tx level during bit period i (start, d0..d7, stop).
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] ovf_exp[5]  = '{10'h260, 10'h262, 10'h264, 10'h266, 10'h268};
    logic [9:0] full_exp[6] = '{10'h222, 10'h224, 10'h226, 10'h228, 10'h22A, 10'h22C};

    initial begin
        int push_cyc;
        int s;

        vecs[0] = '{8'h41, 10'h282};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'hA5, 10'h34A};
        vecs[4] = '{8'h20, 10'h240};

        // Reset state
        tick();
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_tx", tx, 1'b1);

        // Single-byte frames from the table
        for (int i = 0; i < 5; i++) begin
            rxq.delete();
            push_cyc = cyc;
            strobe(vecs[i].data);
            chk($sformatf("v%0d_count", i), fifo_count, 3'd1);
            wait_frames($sformatf("v%0d", i), 1, 100);
            wait_idle($sformatf("v%0d", i), 20);
            if (rxq.size() > 0) begin
                chk($sformatf("v%0d_bits", i), rxq[0].bits, vecs[i].frame);
                chk($sformatf("v%0d_clean", i), rxq[0].clean, 1);
                chk($sformatf("v%0d_latency", i), rxq[0].start - push_cyc, 2);
                chk($sformatf("v%0d_busy_len", i), busy_fall - rxq[0].start, 40);
            end
            chk($sformatf("v%0d_overflow", i), overflow, 1'b0);
            tick();
            tick();
        end

        // Back-to-back 0x55, 0xAA
        rxq.delete();
        strobe(8'h55);
        chk("b2b_count_a", fifo_count, 3'd1);
        strobe(8'hAA);
        chk("b2b_count_b", fifo_count, 3'd1);
        chk("b2b_tx_start", tx, 1'b0);
        wait_frames("b2b", 2, 200);
        chk("b2b_count_end", fifo_count, 3'd0);
        wait_idle("b2b", 20);
        if (rxq.size() == 2) begin
            chk("b2b_bits0", rxq[0].bits, 10'h2AA);
            chk("b2b_bits1", rxq[1].bits, 10'h354);
            chk("b2b_gap", rxq[1].gap, 0);
            chk("b2b_total", busy_fall - rxq[0].start, 80);
        end

        // Overflow: six consecutive pushes, sixth dropped
        tick();
        rxq.delete();
        for (int i = 0; i < 6; i++) strobe(8'h30 + 8'(i));
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", fifo_count, 3'd4);
        wait_frames("ovf", 5, 400);
        wait_idle("ovf", 50);
        chk("ovf_nframes", rxq.size(), 5);
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            chk($sformatf("ovf_bits%0d", i), rxq[i].bits, ovf_exp[i]);
        chk("ovf_sticky", overflow, 1'b1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);

        // Drop on the clearing edge: the drop wins
        rxq.delete();
        for (int i = 0; i < 5; i++) strobe(8'h30 + 8'(i));
        clear_overflow = 1'b1;
        strobe(8'h35);
        clear_overflow = 1'b0;
        chk("drop_wins", overflow, 1'b1);
        wait_frames("drop", 5, 400);
        wait_idle("drop", 50);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        chk("drop_cleared", overflow, 1'b0);

        // Push on the pop edge while full
        rxq.delete();
        for (int i = 0; i < 5; i++) strobe(8'h11 + 8'(i));
        chk("full_count", fifo_count, 3'd4);
        s = mon_start;
        for (int k = 0; k < 60 && cyc < s + 39; k++) tick();
        chk("full_align", cyc, s + 39);
        strobe(8'h16);
        chk("full_same_edge_count", fifo_count, 3'd4);
        chk("full_same_edge_ovf", overflow, 1'b0);
        wait_frames("full", 6, 400);
        wait_idle("full", 50);
        chk("full_nframes", rxq.size(), 6);
        for (int i = 0; i < 6 && i < rxq.size(); i++) begin
            chk($sformatf("full_bits%0d", i), rxq[i].bits, full_exp[i]);
            if (i > 0) chk($sformatf("full_gap%0d", i), rxq[i].gap, 0);
        end

        // Reset during data bit 3 of 0x41 (a low bit), with a second byte queued
        tick();
        rxq.delete();
        strobe(8'h41);
        strobe(8'h42);
        s = mon_start;
        for (int k = 0; k < 40 && cyc < s + 17; k++) tick();
        chk("mid_pre_tx", tx, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        rxq.delete();
        tick();
        strobe(8'h20);
        wait_frames("mid_after", 1, 100);
        wait_idle("mid_after", 20);
        chk("mid_after_nframes", rxq.size(), 1);
        if (rxq.size() > 0) begin
            chk("mid_after_bits", rxq[0].bits, 10'h240);
            chk("mid_after_clean", rxq[0].clean, 1);
        end

        // "Hi" as the core would emit it: second strobe arrives mid-frame
        tick();
        rxq.delete();
        strobe(8'h48);
        for (int k = 0; k < 15; k++) tick();
        strobe(8'h69);
        wait_frames("hi", 2, 200);
        wait_idle("hi", 20);
        if (rxq.size() == 2) begin
            chk("hi_bits0", rxq[0].bits, 10'h290);
            chk("hi_bits1", rxq[1].bits, 10'h2D2);
            chk("hi_gap", rxq[1].gap, 0);
        end
        chk("hi_overflow", overflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
